// File: rtl/param_sync_fifo_if.sv
// +------------------------------------------------------------------+
// | param_sync_fifo_if : write/read/status bundle for param_sync_fifo |
// | Revision 1.0                                                      |
// +------------------------------------------------------------------+
`default_nettype none

interface param_sync_fifo_if #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 16
);
  localparam int LEVEL_W = $clog2(DEPTH) + 1;

  logic                  clr_i;
  logic                  wr_en_i;
  logic [DATA_WIDTH-1:0] wr_data_i;
  logic                  full_o;
  logic                  almost_full_o;
  logic                  rd_en_i;
  logic [DATA_WIDTH-1:0] rd_data_o;
  logic                  rd_valid_o;
  logic                  empty_o;
  logic                  almost_empty_o;
  logic [LEVEL_W-1:0]    level_o;
  logic                  ovf_o;
  logic                  udf_o;

  modport master (
    output clr_i, wr_en_i, wr_data_i, rd_en_i,
    input  full_o, almost_full_o, rd_data_o, rd_valid_o,
           empty_o, almost_empty_o, level_o, ovf_o, udf_o
  );

  modport slave (
    input  clr_i, wr_en_i, wr_data_i, rd_en_i,
    output full_o, almost_full_o, rd_data_o, rd_valid_o,
           empty_o, almost_empty_o, level_o, ovf_o, udf_o
  );
endinterface

`default_nettype wire

// File: rtl/param_sync_fifo.sv
// +------------------------------------------------------------------+
// | param_sync_fifo : single-clock FIFO, FWFT/registered read, flags  |
// | Option macro SFIFO_ERR_STICKY_EN: ovf/udf held until clr or reset |
// | Revision 1.0                                                      |
// +------------------------------------------------------------------+
`default_nettype none

module param_sync_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 16,
  parameter int AF_THRESH  = DEPTH - 2,
  parameter int AE_THRESH  = 2,
  parameter int FWFT       = 0
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  param_sync_fifo_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         level_q, level_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;
  logic                  full, empty;
  logic                  wr_acc, rd_acc;
  logic                  ovf_evt, udf_evt;

  // Accept decisions use the registered level only; clr_i overrides both sides.
  always_comb begin
    full    = (level_q == LW'(DEPTH));
    empty   = (level_q == '0);
    wr_acc  = bus.wr_en_i & ~full  & ~bus.clr_i;
    rd_acc  = bus.rd_en_i & ~empty & ~bus.clr_i;
    ovf_evt = bus.wr_en_i & full;
    udf_evt = bus.rd_en_i & empty;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;

    if (bus.clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_acc) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({wr_acc, rd_acc})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
`ifdef SFIFO_ERR_STICKY_EN
      ovf_d = ovf_q | ovf_evt;
      udf_d = udf_q | udf_evt;
`else
      ovf_d = ovf_evt;
      udf_d = udf_evt;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage is deliberately left without reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= bus.wr_data_i;
  end

  assign bus.full_o         = full;
  assign bus.empty_o        = empty;
  assign bus.almost_full_o  = (level_q >= LW'(AF_THRESH));
  assign bus.almost_empty_o = (level_q <= LW'(AE_THRESH));
  assign bus.level_o        = level_q;
  assign bus.ovf_o          = ovf_q;
  assign bus.udf_o          = udf_q;

  generate
    if (FWFT != 0) begin : g_fwft
      assign bus.rd_data_o  = mem_q[rd_ptr_q];
      assign bus.rd_valid_o = ~empty;
    end else begin : g_reg_read
      logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
      logic                  rd_valid_q, rd_valid_d;

      always_comb begin
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        if (bus.clr_i) begin
          rd_data_d = '0;
        end else if (rd_acc) begin
          rd_data_d  = mem_q[rd_ptr_q];
          rd_valid_d = 1'b1;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rd_data_q  <= '0;
          rd_valid_q <= 1'b0;
        end else begin
          rd_data_q  <= rd_data_d;
          rd_valid_q <= rd_valid_d;
        end
      end

      assign bus.rd_data_o  = rd_data_q;
      assign bus.rd_valid_o = rd_valid_q;
    end
  endgenerate

endmodule

`default_nettype wire
